// File: rtl/cpu_pkg.sv
// Shared fetch-path types and constants: sequencer state encoding, reset/exception PCs.
package cpu_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC    = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR  = 32'h0040_0004;
  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_sequencer_redirect_sel.sv
// Priority mux over redirect sources: exception, then jump, then taken branch.
module redirect_sel
  import cpu_pkg::*;
(
  input  logic        exc_i,
  input  logic        jump_i,
  input  logic        br_taken_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] br_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  always_comb begin
    redirect_o = exc_i | jump_i | br_taken_i;
    target_o   = br_target_i;
    if (exc_i) begin
      target_o = EXC_VECTOR;
    end else if (jump_i) begin
      target_o = jump_target_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: drives PC register load, single-outstanding imem request
// and the valid/ready hand-off of fetched words to decode.
module fetch_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        id_ready,
  input  logic        stall,
  input  logic        exc,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        br_taken,
  input  logic [31:0] br_target
);

  fetch_state_e state_q, state_d;
  logic [31:0]  imem_addr_q, imem_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;

  logic         redirect;
  logic [31:0]  redirect_target;
  logic         take_redirect;

  redirect_sel u_redirect_sel (
    .exc_i         (exc),
    .jump_i        (jump),
    .br_taken_i    (br_taken),
    .jump_target_i (jump_target),
    .br_target_i   (br_target),
    .redirect_o    (redirect),
    .target_o      (redirect_target)
  );

  // BOOT ignores redirects so the first fetch always comes from the reset PC.
  assign take_redirect = redirect && (state_q != BOOT);

  always_comb begin
    state_d     = state_q;
    imem_addr_d = imem_addr_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    pc_ena      = 1'b0;
    pc_next     = seq_pc(pc_in);

    if (take_redirect) begin
      pc_ena  = 1'b1;
      pc_next = redirect_target;
    end

    case (state_q)
      BOOT: begin
        state_d     = FETCH;
        imem_addr_d = pc_in;
      end
      FETCH: begin
        if (take_redirect) begin
          // Acked data belongs to the squashed path; with no ack the request
          // must still be retired before the address may move.
          if (imem_ack) begin
            imem_addr_d = redirect_target;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = imem_addr_q;
          pc_ena     = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (take_redirect) begin
          state_d     = FETCH;
          imem_addr_d = redirect_target;
        end else if (id_ready && !stall) begin
          state_d     = FETCH;
          imem_addr_d = pc_in;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_d     = FETCH;
          imem_addr_d = pc_ena ? pc_next : pc_in;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      imem_addr_q <= RESET_PC;
      instr_q     <= '0;
      instr_pc_q  <= '0;
    end else begin
      state_q     <= state_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign instr_valid = (state_q == HOLD);
  assign imem_addr   = imem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: PC register and instruction memory are
// modelled here; acked fetches and accepted instructions are checked against queues.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready;
  logic        stall;
  logic        exc;
  logic        jump;
  logic [31:0] jump_target;
  logic        br_taken;
  logic [31:0] br_target;

  typedef struct packed {
    logic [31:0] addr;
    logic        drain;
  } fetch_exp_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } instr_exp_t;

  fetch_exp_t fq[$];
  instr_exp_t iq[$];
  fetch_exp_t fe;
  instr_exp_t ie;
  int         acc_cyc[$];

  int n_cmp     = 0;
  int n_mis     = 0;
  int n_acc     = 0;
  int cyc       = 0;
  int ack_delay = 0;
  int waited    = 0;

  logic [31:0] pc_q;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_ena      (pc_ena),
    .pc_next     (pc_next),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .id_ready    (id_ready),
    .stall       (stall),
    .exc         (exc),
    .jump        (jump),
    .jump_target (jump_target),
    .br_taken    (br_taken),
    .br_target   (br_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC register, reset together with the sequencer.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_q <= 32'h0040_0000;
    else if (pc_ena) pc_q <= pc_next;
  end
  assign pc_in = pc_q;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h8C08_0000 ^ (a - 32'h0040_0000);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Memory: acks after ack_delay wait cycles, one request at a time.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !imem_req) begin
        waited   = 0;
        imem_ack = 1'b0;
      end else begin
        if (imem_ack) waited = 0;
        imem_ack   = (waited >= ack_delay);
        imem_rdata = memf(imem_addr);
        if (!imem_ack) waited++;
      end
    end
  end

  // Fetch monitor: every acked request, including discarded ones.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && imem_req && imem_ack) begin
        if (fq.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_ack: got addr %h, required no request", imem_addr);
        end else begin
          fe = fq.pop_front();
          chk("ack_addr", imem_addr, fe.addr);
          if (fe.drain) begin
            chk("drain_pc_ena", 32'(pc_ena), 32'd0);
          end else begin
            chk("ack_pc_ena", 32'(pc_ena), 32'd1);
            chk("ack_pc_next", pc_next, fe.addr + 32'd4);
          end
        end
      end
    end
  end

  // Decode monitor: every instruction accepted by decode.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && id_ready && !stall) begin
        n_acc++;
        acc_cyc.push_back(cyc);
        if (iq.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_instr: got %h at %h, required none", instr, instr_pc);
        end else begin
          ie = iq.pop_front();
          chk("instr", instr, ie.word);
          chk("instr_pc", instr_pc, ie.pc);
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0040_0000);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
    chk({tag, "_pc_ena"}, 32'(pc_ena), 32'd0);
  endtask

  task automatic reset_dut();
    tick();
    rst = 1'b1;
    @(negedge clk);
    check_reset_values("rst");
    chk("rst_pc_next", pc_next, 32'h0040_0004);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; id_ready = 1'b0; stall = 1'b0;
    exc = 1'b0; jump = 1'b0; br_taken = 1'b0;
    jump_target = '0; br_target = '0;

    // Zero-wait memory, decode always ready.
    ack_delay = 0;
    id_ready  = 1'b1;
    fq.push_back('{32'h0040_0000, 1'b0});
    fq.push_back('{32'h0040_0004, 1'b0});
    fq.push_back('{32'h0040_0008, 1'b0});
    fq.push_back('{32'h0040_000C, 1'b0});
    iq.push_back('{32'h0040_0000, 32'h8C08_0000});
    iq.push_back('{32'h0040_0004, 32'h8C08_0004});
    iq.push_back('{32'h0040_0008, 32'h8C08_0008});
    n_acc = 0;
    acc_cyc.delete();
    reset_dut();
    for (int i = 0; i < 40 && n_acc < 3; i++) tick();
    id_ready = 1'b0;
    for (int i = 0; i < 10 && fq.size() != 0; i++) tick();
    chk("t1_fetch_left", fq.size(), 32'd0);
    chk("t1_instr_left", iq.size(), 32'd0);
    chk("t1_accepts", acc_cyc.size(), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("t1_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
      chk("t1_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);
    end

    // Ack delayed three cycles; decode not ready so the word stays in HOLD.
    ack_delay = 3;
    fq.push_back('{32'h0040_0000, 1'b0});
    reset_dut();
    @(negedge clk);
    chk("t2_boot_req", 32'(imem_req), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_wait_req", 32'(imem_req), 32'd1);
      chk("t2_wait_addr", imem_addr, 32'h0040_0000);
      chk("t2_wait_pc_ena", 32'(pc_ena), 32'd0);
      chk("t2_wait_valid", 32'(instr_valid), 32'd0);
    end
    @(negedge clk);
    chk("t2_ack_addr", imem_addr, 32'h0040_0000);
    @(negedge clk);
    chk("t2_valid", 32'(instr_valid), 32'd1);
    chk("t2_instr", instr, 32'h8C08_0000);
    chk("t2_instr_pc", instr_pc, 32'h0040_0000);

    // HOLD under stall for five cycles, then release.
    tick();
    stall    = 1'b1;
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", 32'(instr_valid), 32'd1);
      chk("t3_hold_instr", instr, 32'h8C08_0000);
      chk("t3_hold_req", 32'(imem_req), 32'd0);
      tick();
    end
    stall     = 1'b0;
    ack_delay = 3;
    iq.push_back('{32'h0040_0000, 32'h8C08_0000});
    fq.push_back('{32'h0040_0004, 1'b1});
    @(negedge clk);
    chk("t3_release_req", 32'(imem_req), 32'd0);
    tick();
    id_ready = 1'b0;
    @(negedge clk);
    chk("t3_next_req", 32'(imem_req), 32'd1);
    chk("t3_next_addr", imem_addr, 32'h0040_0004);

    // Branch while the request is outstanding: drain and discard.
    tick();
    br_taken  = 1'b1;
    br_target = 32'h0040_0100;
    @(negedge clk);
    chk("t4_br_pc_ena", 32'(pc_ena), 32'd1);
    chk("t4_br_pc_next", pc_next, 32'h0040_0100);
    tick();
    br_taken  = 1'b0;
    ack_delay = 0;
    fq.push_back('{32'h0040_0100, 1'b0});
    @(negedge clk);
    chk("t4_drain_req", 32'(imem_req), 32'd1);
    chk("t4_drain_addr", imem_addr, 32'h0040_0004);
    chk("t4_drain_valid", 32'(instr_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_valid) break;
    end
    chk("t4_target_valid", 32'(instr_valid), 32'd1);
    chk("t4_target_pc", instr_pc, 32'h0040_0100);
    chk("t4_target_instr", instr, 32'h8C08_0100);
    chk("t4_fetch_left", fq.size(), 32'd0);

    // All three redirect sources at once from HOLD.
    tick();
    exc         = 1'b1;
    jump        = 1'b1;
    br_taken    = 1'b1;
    jump_target = 32'h0040_0200;
    br_target   = 32'h0040_0300;
    ack_delay   = 3;
    @(negedge clk);
    chk("t5_pc_ena", 32'(pc_ena), 32'd1);
    chk("t5_pc_next", pc_next, 32'h0040_0004);
    tick();
    exc = 1'b0; jump = 1'b0; br_taken = 1'b0;
    @(negedge clk);
    chk("t5_req", 32'(imem_req), 32'd1);
    chk("t5_addr", imem_addr, 32'h0040_0004);

    // Jump into DRAIN, then reset asynchronously mid-cycle.
    tick();
    jump = 1'b1;
    @(negedge clk);
    chk("t6_jump_pc_next", pc_next, 32'h0040_0200);
    tick();
    jump = 1'b0;
    @(negedge clk);
    chk("t6_drain_req", 32'(imem_req), 32'd1);
    chk("t6_drain_addr", imem_addr, 32'h0040_0004);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("t6_async");
    ack_delay = 0;
    fq.push_back('{32'h0040_0000, 1'b0});
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_release_addr", imem_addr, 32'h0040_0000);
    for (int i = 0; i < 10 && fq.size() != 0; i++) tick();
    chk("t6_fetch_left", fq.size(), 32'd0);

    chk("end_instr_left", iq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
